// File: rtl/decode_issue_arbiter_if.sv
// Bundle of decoder-side and issue-side signals for the decode issue arbiter.
// The slave modport is the arbiter's view. The master modport is the driver/observer view.
interface decode_issue_arbiter_if #(
    parameter int NUM_DEC   = 4,
    parameter int PAYLOAD_W = 160,
    parameter int MAJID_W   = 64
);
    localparam int IDX_W = (NUM_DEC > 1) ? $clog2(NUM_DEC) : 1;

    logic [NUM_DEC-1:0]           decValid_i;
    logic [NUM_DEC*MAJID_W-1:0]   decMajId_i;
    logic [NUM_DEC*PAYLOAD_W-1:0] decPayload_i;
    logic [NUM_DEC-1:0]           decStall_o;
    logic                         stall_i;
    logic                         valid_o;
    logic [MAJID_W-1:0]           majId_o;
    logic [PAYLOAD_W-1:0]         payload_o;
    logic [IDX_W-1:0]             grantIdx_o;
    logic                         overflowErr_o;

    modport slave (
        input  decValid_i, decMajId_i, decPayload_i, stall_i,
        output decStall_o, valid_o, majId_o, payload_o, grantIdx_o, overflowErr_o
    );

    modport master (
        output decValid_i, decMajId_i, decPayload_i, stall_i,
        input  decStall_o, valid_o, majId_o, payload_o, grantIdx_o, overflowErr_o
    );
endinterface

// File: rtl/decode_issue_arbiter.sv
// Collects bundles from NUM_DEC decoders into one holding slot each.
// Issues them oldest-first (smallest major ID) through a single stallable output register.
module decode_issue_arbiter #(
    parameter int NUM_DEC   = 4,
    parameter int PAYLOAD_W = 160,
    parameter int MAJID_W   = 64
) (
    input logic                   clock_i,
    input logic                   reset_i,
    decode_issue_arbiter_if.slave bus
);
    localparam int IDX_W = (NUM_DEC > 1) ? $clog2(NUM_DEC) : 1;

    logic [NUM_DEC-1:0]   full_q, full_d;
    logic [MAJID_W-1:0]   majid_q   [NUM_DEC];
    logic [PAYLOAD_W-1:0] payload_q [NUM_DEC];

    logic                 valid_q;
    logic [MAJID_W-1:0]   out_majid_q;
    logic [PAYLOAD_W-1:0] out_payload_q;
    logic [IDX_W-1:0]     out_idx_q;
    logic                 overflow_q;

    logic                 advance;
    logic                 any_full;
    logic [IDX_W-1:0]     sel_idx;
    logic [MAJID_W-1:0]   sel_majid;
    logic [NUM_DEC-1:0]   granted;
    logic [NUM_DEC-1:0]   dec_stall;
    logic [NUM_DEC-1:0]   load;

    assign advance = !bus.stall_i || !valid_q;

    // NOTE: blocking assignments are correct here. The loop carries a running
    // minimum from one iteration to the next inside a single combinational evaluation.
    // A strict less-than keeps the lowest index on a major-ID tie.
    always_comb begin
        any_full  = 1'b0;
        sel_idx   = '0;
        sel_majid = '0;
        for (int k = 0; k < NUM_DEC; k++) begin
            if (full_q[k] && (!any_full || majid_q[k] < sel_majid)) begin
                any_full  = 1'b1;
                sel_idx   = IDX_W'(k);
                sel_majid = majid_q[k];
            end
        end
    end

    // NOTE: every variable gets a default before the loop. Without that, a path
    // that skips an assignment would infer a latch.
    always_comb begin
        granted   = '0;
        dec_stall = '0;
        load      = '0;
        full_d    = full_q;
        for (int k = 0; k < NUM_DEC; k++) begin
            granted[k]   = advance && any_full && (sel_idx == IDX_W'(k));
            dec_stall[k] = full_q[k] && !granted[k];
            load[k]      = bus.decValid_i[k] && !dec_stall[k];
            if (load[k])
                full_d[k] = 1'b1;
            else if (granted[k])
                full_d[k] = 1'b0;
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            full_q        <= '0;
            valid_q       <= 1'b0;
            out_majid_q   <= '0;
            out_payload_q <= '0;
            out_idx_q     <= '0;
            overflow_q    <= 1'b0;
        end else begin
            full_q     <= full_d;
            overflow_q <= overflow_q || |(bus.decValid_i & dec_stall);
            if (advance) begin
                valid_q <= any_full;
                if (any_full) begin
                    out_majid_q   <= sel_majid;
                    out_payload_q <= payload_q[sel_idx];
                    out_idx_q     <= sel_idx;
                end
            end
        end
    end

    // NOTE: slot storage is not reset. The full flags alone decide whether a slot's
    // contents are meaningful, so clearing the data as well would add nothing.
    always_ff @(posedge clock_i) begin
        for (int k = 0; k < NUM_DEC; k++) begin
            if (load[k]) begin
                majid_q[k]   <= bus.decMajId_i[k*MAJID_W +: MAJID_W];
                payload_q[k] <= bus.decPayload_i[k*PAYLOAD_W +: PAYLOAD_W];
            end
        end
    end

    assign bus.decStall_o    = dec_stall;
    assign bus.valid_o       = valid_q;
    assign bus.majId_o       = out_majid_q;
    assign bus.payload_o     = out_payload_q;
    assign bus.grantIdx_o    = out_idx_q;
    assign bus.overflowErr_o = overflow_q;
endmodule

// File: doc/decode_issue_arbiter.md
DECODE_ISSUE_ARBITER -- requirements
Module: decode_issue_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_DEC, default 4, giving the number of format-specific decoders feeding the arbiter.
REQ-002 The block SHALL have parameter PAYLOAD_W, default 160, giving the width of one decoded-instruction bundle (opcode, address, functional unit, body, PID, TID, min ID, is64Bit).
REQ-003 The block SHALL have parameter MAJID_W, default 64, giving the width of the instruction major ID.
REQ-004 The block SHALL have port clock_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset_i, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port decValid_i, input, NUM_DEC bits: bit k is decoder k's enable_o.
REQ-007 The block SHALL have port decMajId_i, input, NUM_DEC*MAJID_W bits: the major ID from each decoder, with decoder k in slice k.
REQ-008 The block SHALL have port decPayload_i, input, NUM_DEC*PAYLOAD_W bits: the bundle from each decoder, with decoder k in slice k.
REQ-009 The block SHALL have port decStall_o, output, NUM_DEC bits: the stall_i to each decoder.
REQ-010 The block SHALL have port stall_i, input, 1 bit: downstream back-pressure.
REQ-011 The block SHALL have port valid_o, output, 1 bit: issued bundle valid.
REQ-012 The block SHALL have port majId_o, output, MAJID_W bits: the major ID of the issued bundle.
REQ-013 The block SHALL have port payload_o, output, PAYLOAD_W bits: the issued bundle.
REQ-014 The block SHALL have port grantIdx_o, output, clog2(NUM_DEC) bits: the index of the slot that supplied the current output.
REQ-015 The block SHALL have port overflowErr_o, output, 1 bit: sticky protocol-violation flag.

Function
REQ-016 The block SHALL hold, per decoder k, one holding slot consisting of a full flag, the major ID and the payload.
REQ-017 Slot k SHALL load on a clock edge when decValid_i[k] is 1 and either (the slot is empty) or (the slot is full and granted this cycle).
REQ-018 decStall_o[k] SHALL be combinational and equal to (slot k full) AND NOT (slot k granted this cycle).
REQ-019 Output-register advance SHALL be defined as stall_i equal to 0 OR valid_o equal to 0.
REQ-020 On an output-register advance, the block SHALL grant the full slot with the numerically smallest major ID (oldest-first).
REQ-021 On a major-ID tie between full slots, the grant SHALL go to the lowest slot index.
REQ-022 Major IDs SHALL be compared as unsigned MAJID_W-bit values, with no wrap-around handling.
REQ-023 A granted slot SHALL copy its major ID, payload and index into majId_o, payload_o and grantIdx_o, set valid_o to 1, and clear the slot unless it reloads in the same cycle.
REQ-024 If the output register advances and no slot is full, valid_o SHALL become 0, and payload_o, majId_o and grantIdx_o SHALL hold their previous values.
REQ-025 While stall_i is 1 and valid_o is 1, all outputs SHALL hold and no slot SHALL be granted; slots SHALL still load while empty.
REQ-026 Exactly one slot SHALL be granted per cycle at most; issue throughput SHALL be at most 1 bundle per cycle.
REQ-027 Latency SHALL be exactly 2 edges from decValid_i[k] to valid_o (slot load, then output register) when unstalled and slot k is the oldest.
REQ-028 If decValid_i[k] is 1 while decStall_o[k] is 1, the input SHALL be dropped, the slot SHALL keep its old contents, and overflowErr_o SHALL be set to 1 until reset.
REQ-029 Simultaneous valids on several decoders SHALL all be captured in the same cycle, into their own slots.

Reset
REQ-030 While reset_i is 0, the block SHALL asynchronously clear all slot full flags, valid_o, overflowErr_o, majId_o, payload_o and grantIdx_o to 0.
REQ-031 Assertion of reset_i mid-operation SHALL discard all held and in-flight bundles, with no partial output.
REQ-032 After release of reset_i, the first rising edge SHALL be able to load slots.

Verification
REQ-033 Single valid: decValid_i=0001, majId 5, stall_i=0 -> valid_o=1 with majId_o=5 and grantIdx_o=0 two edges later, and valid_o=0 on the following edge.
REQ-034 Oldest-first: decValid_i=1111 in one cycle with majIds 9,3,7,3 -> majId_o sequence 3 (idx1), 3 (idx3), 7 (idx2), 9 (idx0) on 4 consecutive edges.
REQ-035 Back-pressure: with slot 2 full and stall_i=1 for 3 cycles -> decStall_o[2]=1 throughout and outputs held; after release, slot 2 issues and decStall_o[2] drops in that same cycle.
REQ-036 Grant-and-reload: slot 0 full and granted while decValid_i[0]=1 (majId 8) -> no stall and no overflow, with majId_o=8 on the next advance.
REQ-037 Overflow: decValid_i[1]=1 while decStall_o[1]=1 -> overflowErr_o=1, the original slot-1 bundle is issued intact, and the flag stays at 1 until reset_i=0.
REQ-038 Reset mid-stream: reset_i=0 with 3 slots full and valid_o=1 -> all outputs 0 immediately, and no issue after release without new valids.
